timer_sequencer: RTL and testbench

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_sequencer_btn_edge.sv | 46 ++++
 rtl/timer_sequencer.sv | 124 ++++++++++++
 tb/tb_timer_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS timer sequencer: mode codes, digit maxima,
// button index map and the wrapping digit increment used by the preset editor.
package timer_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_BTNS   = 6;

  localparam int unsigned DEF_MAX_D0 = 9;
  localparam int unsigned DEF_MAX_D1 = 5;
  localparam int unsigned DEF_MAX_D2 = 9;
  localparam int unsigned DEF_MAX_D3 = 5;

  // Bit positions of the edge-detected button events
  localparam int unsigned EV_CLEAR = 0;
  localparam int unsigned EV_SET   = 1;
  localparam int unsigned EV_START = 2;
  localparam int unsigned EV_STOP  = 3;
  localparam int unsigned EV_NEXT  = 4;
  localparam int unsigned EV_INC   = 5;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SET   = 4'd1,
    PAUSE = 4'd2,
    RUN   = 4'd3
  } state_e;

  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] val,
                                                   input logic [DIGIT_W-1:0] max);
    return (val >= max) ? DIGIT_W'(0) : val + DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/timer_sequencer_btn_edge.sv
// One-bit button rising-edge detector; with TIMER_SEQUENCER_BTN_SYNC_EN defined a
// two-flop synchronizer precedes the detector.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_c_o
);

`ifdef TIMER_SEQUENCER_BTN_SYNC_EN
  localparam int unsigned ARM_CYCLES = 3;
  logic [1:0] sync_q;
  logic       sig;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_i};
  end
  assign sig = sync_q[1];
`else
  localparam int unsigned ARM_CYCLES = 1;
  logic sig;
  assign sig = btn_i;
`endif

  logic       prev_q;
  logic [1:0] arm_q;
  logic       armed;

  // Events stay masked until the history holds a real post-reset sample, so a
  // button held through reset release is not seen as a press.
  assign armed = (arm_q == 2'(ARM_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      prev_q <= sig;
      if (!armed) arm_q <= arm_q + 2'd1;
    end
  end

  assign rise_c_o = sig & ~prev_q & armed;

endmodule

// File: rtl/timer_sequencer.sv
// MM:SS timer control: button events drive the mode FSM and preset editor, and a
// one-second prescaler produces tick and per-digit carry strobes.
// Optional input synchronizers: define TIMER_SEQUENCER_BTN_SYNC_EN.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned MAX_D0   = DEF_MAX_D0,
  parameter int unsigned MAX_D1   = DEF_MAX_D1,
  parameter int unsigned MAX_D2   = DEF_MAX_D2,
  parameter int unsigned MAX_D3   = DEF_MAX_D3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_clear,
  input  logic        btn_set,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic [15:0] digit_val,
  output logic [3:0]  state,
  output logic [15:0] set_vals,
  output logic [1:0]  cursor,
  output logic [3:0]  digit_en,
  output logic        tick,
  output logic        wrap
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] MAX_VEC = {4'(MAX_D3), 4'(MAX_D2), 4'(MAX_D1), 4'(MAX_D0)};

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] ev;

  state_e               state_q, state_d;
  logic [15:0]          set_vals_q, set_vals_d;
  logic [1:0]           cursor_q, cursor_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 at_top;
  logic [3:0]           cur_idx;
  logic [NUM_DIGITS-1:0] max_hit;

  assign btn_raw = {btn_inc, btn_next, btn_stop, btn_start, btn_set, btn_clear};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_edge u_btn_edge (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_raw[g]),
      .rise_c_o (ev[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      set_vals_q <= '0;
      cursor_q   <= '0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      set_vals_q <= set_vals_d;
      cursor_q   <= cursor_d;
      presc_q    <= presc_d;
    end
  end

  // Highest-priority event wins; the others are dropped even if the winner is ignored.
  always_comb begin
    state_d = state_q;
    if (ev[EV_CLEAR]) begin
      state_d = IDLE;
    end else if (ev[EV_START]) begin
      if (state_q != RUN) state_d = RUN;
    end else if (ev[EV_SET]) begin
      if (state_q == IDLE || state_q == PAUSE) state_d = SET;
    end else if (ev[EV_STOP]) begin
      if (state_q == RUN) state_d = PAUSE;
    end
  end

  assign cur_idx = {cursor_q, 2'b00};

  always_comb begin
    set_vals_d = set_vals_q;
    cursor_d   = cursor_q;
    if (state_q == SET) begin
      if (ev[EV_NEXT]) cursor_d = cursor_q + 2'd1;
      if (ev[EV_INC])
        set_vals_d[cur_idx +: 4] = digit_inc(set_vals_q[cur_idx +: 4], MAX_VEC[cur_idx +: 4]);
    end
  end

  assign at_top = (presc_q == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = '0;
    case (state_q)
      RUN:     presc_d = at_top ? '0 : presc_q + PRESC_W'(1);
      PAUSE:   presc_d = presc_q;
      default: presc_d = '0;
    endcase
  end

  // Gated by reset so a reset cycle never emits a tick.
  assign tick = (state_q == RUN) && at_top && !reset;

  always_comb begin
    max_hit  = '0;
    digit_en = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      max_hit[i] = (digit_val[4*i +: 4] == MAX_VEC[4*i +: 4]);
    digit_en[0] = tick;
    for (int i = 1; i < NUM_DIGITS; i++)
      digit_en[i] = digit_en[i-1] & max_hit[i-1];
  end

  assign wrap     = digit_en[3] & max_hit[3];
  assign state    = state_q;
  assign set_vals = set_vals_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with TICK_DIV=4 and no input synchronizers.
module tb_timer_sequencer;

  localparam int unsigned B_CLEAR = 0;
  localparam int unsigned B_SET   = 1;
  localparam int unsigned B_START = 2;
  localparam int unsigned B_STOP  = 3;
  localparam int unsigned B_NEXT  = 4;
  localparam int unsigned B_INC   = 5;

  logic        clk;
  logic        reset;
  logic [5:0]  btn;
  logic [15:0] digit_val;
  logic [3:0]  state;
  logic [15:0] set_vals;
  logic [1:0]  cursor;
  logic [3:0]  digit_en;
  logic        tick;
  logic        wrap;

  int checks = 0;
  int errors = 0;
  int n_ticks;

  timer_sequencer #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_clear (btn[B_CLEAR]),
    .btn_set   (btn[B_SET]),
    .btn_start (btn[B_START]),
    .btn_stop  (btn[B_STOP]),
    .btn_next  (btn[B_NEXT]),
    .btn_inc   (btn[B_INC]),
    .digit_val (digit_val),
    .state     (state),
    .set_vals  (set_vals),
    .cursor    (cursor),
    .digit_en  (digit_en),
    .tick      (tick),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int unsigned b);
    btn[b] = 1'b1;
    cyc();
    btn[b] = 1'b0;
    cyc();
  endtask

  initial begin
    reset     = 1'b1;
    btn       = '0;
    digit_val = '0;
    cyc();
    cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_set_vals", 32'(set_vals), 32'h0);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);

    // Start held across reset release must not start the timer
    btn[B_START] = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (4) cyc();
    check("held_thru_reset", 32'(state), 32'd0);
    btn[B_START] = 1'b0;
    repeat (2) cyc();

    // Held start: RUN once, tick every 4th cycle, only digit 0 strobed
    btn[B_START] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("run_state", 32'(state), 32'd3);
      check("run_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      check("run_digit_en", 32'(digit_en), (k % 4 == 0) ? 32'h1 : 32'h0);
      if (k == 10) btn[B_START] = 1'b0;
    end

    // Carry chain
    digit_val = 16'h0059;
    repeat (3) cyc();
    check("carry_pre_tick", 32'(tick), 32'd0);
    check("carry_pre_en", 32'(digit_en), 32'h0);
    cyc();
    check("carry3_tick", 32'(tick), 32'd1);
    check("carry3_en", 32'(digit_en), 32'h7);
    check("carry3_wrap", 32'(wrap), 32'd0);
    digit_val = 16'h5959;
    repeat (3) cyc();
    check("wrap_pre", 32'(wrap), 32'd0);
    cyc();
    check("wrap_en", 32'(digit_en), 32'hf);
    check("wrap_pulse", 32'(wrap), 32'd1);
    digit_val = 16'h0000;

    // Stop while prescaler is 1: paused with prescaler 2, resume ticks on 2nd RUN cycle
    repeat (2) cyc();
    btn[B_STOP] = 1'b1;
    cyc();
    check("stop_pause", 32'(state), 32'd2);
    btn[B_STOP] = 1'b0;
    n_ticks = 0;
    repeat (20) begin
      cyc();
      if (tick) n_ticks++;
    end
    check("pause_no_tick", 32'(n_ticks), 32'd0);
    check("pause_hold", 32'(state), 32'd2);
    btn[B_START] = 1'b1;
    cyc();
    check("resume_state", 32'(state), 32'd3);
    check("resume_c1_tick", 32'(tick), 32'd0);
    btn[B_START] = 1'b0;
    cyc();
    check("resume_c2_tick", 32'(tick), 32'd1);

    // Set ignored in RUN; clear beats start in PAUSE and zeroes the prescaler
    btn[B_SET] = 1'b1;
    cyc();
    check("set_in_run", 32'(state), 32'd3);
    btn[B_SET] = 1'b0;
    cyc();
    press(B_STOP);
    check("stop2", 32'(state), 32'd2);
    btn[B_CLEAR] = 1'b1;
    btn[B_START] = 1'b1;
    cyc();
    check("clear_over_start", 32'(state), 32'd0);
    btn = '0;
    cyc();
    btn[B_START] = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      cyc();
      btn[B_START] = 1'b0;
      check("presc_zeroed", 32'(tick), (r == 4) ? 32'd1 : 32'd0);
    end
    press(B_CLEAR);
    check("clear_in_run", 32'(state), 32'd0);

    // Preset editing
    press(B_SET);
    check("enter_set", 32'(state), 32'd1);
    press(B_NEXT);
    press(B_NEXT);
    check("cursor2", 32'(cursor), 32'd2);
    for (int i = 1; i <= 11; i++) begin
      press(B_INC);
      if (i == 9)  check("inc9", 32'(set_vals), 32'h0900);
      if (i == 10) check("inc10_wrap", 32'(set_vals), 32'h0000);
      if (i == 11) check("inc11", 32'(set_vals), 32'h0100);
    end
    repeat (3) press(B_NEXT);
    check("cursor_wrap", 32'(cursor), 32'd1);
    repeat (7) press(B_INC);
    check("d1_wrap_at5", 32'(set_vals), 32'h0110);
    press(B_CLEAR);
    check("clear_state", 32'(state), 32'd0);
    check("keep_set_vals", 32'(set_vals), 32'h0110);
    check("keep_cursor", 32'(cursor), 32'd1);
    press(B_INC);
    check("inc_idle_ignored", 32'(set_vals), 32'h0110);
    press(B_NEXT);
    check("next_idle_ignored", 32'(cursor), 32'd1);

    // Reset mid-RUN at prescaler 3
    btn[B_START] = 1'b1;
    cyc();
    check("run_again", 32'(state), 32'd3);
    btn[B_START] = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    check("rst_run_tick", 32'(tick), 32'd0);
    check("rst_run_en", 32'(digit_en), 32'h0);
    cyc();
    check("rst_run_state", 32'(state), 32'd0);
    check("rst_run_set_vals", 32'(set_vals), 32'h0);
    check("rst_run_cursor", 32'(cursor), 32'd0);
    check("rst_run_tick2", 32'(tick), 32'd0);
    check("rst_run_wrap", 32'(wrap), 32'd0);
    reset = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
